// File: rtl/bus_initiator_if.sv
// Host request and 8088-style bus signals for bus_initiator.
// master is the initiator side; slave is the host/responder side.
interface bus_initiator_if #(
  parameter int unsigned ADDR_WIDTH = 20,
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  req;
  logic                  req_write;
  logic                  req_io;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  req_ready;
  logic                  done;
  logic                  timeout;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  ALE;
  logic                  IOM;
  logic                  RD;
  logic                  WR;
  logic                  READY;
  logic [ADDR_WIDTH-1:0] Address;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  data_oe;
  logic [DATA_WIDTH-1:0] data_in;

  modport master (
    input  req, req_write, req_io, req_addr, req_wdata, READY, data_in,
    output req_ready, done, timeout, rdata, ALE, IOM, RD, WR, Address, data_out, data_oe
  );

  modport slave (
    output req, req_write, req_io, req_addr, req_wdata, READY, data_in,
    input  req_ready, done, timeout, rdata, ALE, IOM, RD, WR, Address, data_out, data_oe
  );
endinterface

// File: rtl/bus_initiator.sv
// Bus cycle initiator: turns one host request into a T1..T4 bus cycle with
// READY-driven wait states and a wait-state timeout.
module bus_initiator #(
  parameter int unsigned ADDR_WIDTH = 20,
  parameter int unsigned DATA_WIDTH = 8,
  parameter bit          IO_SELECT  = 1'b1,
  parameter int unsigned MAX_WAIT   = 15
) (
  input logic             CLK,
  input logic             RESET,
  bus_initiator_if.master bus
);

  localparam int unsigned WAIT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

  typedef enum logic [2:0] {IDLE, T1, T2, T3, TW, T4} state_t;

  state_t                state;
  logic [WAIT_W-1:0]     wait_cnt;
  logic                  lat_write;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [DATA_WIDTH-1:0] lat_wdata;

  // Address only changes when a request is accepted, so it holds between cycles.
  assign bus.Address = lat_addr;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state         <= IDLE;
      wait_cnt      <= '0;
      lat_write     <= 1'b0;
      lat_addr      <= '0;
      lat_wdata     <= '0;
      bus.req_ready <= 1'b1;
      bus.done      <= 1'b0;
      bus.timeout   <= 1'b0;
      bus.rdata     <= '0;
      bus.ALE       <= 1'b0;
      bus.IOM       <= ~IO_SELECT;
      bus.RD        <= 1'b1;
      bus.WR        <= 1'b1;
      bus.data_out  <= '0;
      bus.data_oe   <= 1'b0;
    end else begin
      bus.ALE     <= 1'b0;
      bus.done    <= 1'b0;
      bus.timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req) begin
            state         <= T1;
            bus.req_ready <= 1'b0;
            lat_write     <= bus.req_write;
            lat_addr      <= bus.req_addr;
            lat_wdata     <= bus.req_wdata;
            wait_cnt      <= '0;
            bus.ALE       <= 1'b1;
            bus.IOM       <= bus.req_io ? IO_SELECT : ~IO_SELECT;
          end
        end
        T1: begin
          state <= T2;
          if (lat_write) begin
            bus.WR       <= 1'b0;
            bus.data_oe  <= 1'b1;
            bus.data_out <= lat_wdata;
          end else begin
            bus.RD <= 1'b0;
          end
        end
        T2: state <= T3;
        T3, TW: begin
          if (bus.READY) begin
            state       <= T4;
            bus.RD      <= 1'b1;
            bus.WR      <= 1'b1;
            bus.data_oe <= 1'b0;
            bus.done    <= 1'b1;
            if (!lat_write) bus.rdata <= bus.data_in;
          end else if (wait_cnt == WAIT_W'(MAX_WAIT)) begin
            // Responder never answered: end the cycle, keep old rdata.
            state       <= T4;
            bus.RD      <= 1'b1;
            bus.WR      <= 1'b1;
            bus.data_oe <= 1'b0;
            bus.done    <= 1'b1;
            bus.timeout <= 1'b1;
          end else begin
            state    <= TW;
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        T4: begin
          state         <= IDLE;
          bus.req_ready <= 1'b1;
        end
        default: begin
          state         <= IDLE;
          bus.req_ready <= 1'b1;
          bus.RD        <= 1'b1;
          bus.WR        <= 1'b1;
          bus.data_oe   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_initiator.sv
// Directed bench for bus_initiator: read, write, wait states, timeout,
// reset abort and back-to-back requests.
module tb_bus_initiator;

  logic CLK = 1'b0;
  logic RESET;
  int   n_checks = 0;
  int   n_fail   = 0;

  bus_initiator_if #(.ADDR_WIDTH(20), .DATA_WIDTH(8)) bus ();

  bus_initiator #(
    .ADDR_WIDTH(20), .DATA_WIDTH(8), .IO_SELECT(1'b1), .MAX_WAIT(15)
  ) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  // {ALE, IOM, RD, WR, data_oe, done, timeout, req_ready}
  logic [7:0] ctl;
  assign ctl = {bus.ALE, bus.IOM, bus.RD, bus.WR, bus.data_oe, bus.done, bus.timeout, bus.req_ready};

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Present one request for a single edge; returns in T1.
  task automatic issue(input logic wr, input logic io, input logic [19:0] addr, input logic [7:0] wd);
    bus.req = 1'b1; bus.req_write = wr; bus.req_io = io; bus.req_addr = addr; bus.req_wdata = wd;
    tick();
    bus.req = 1'b0; bus.req_addr = 20'hFFFFF; bus.req_wdata = 8'hEE;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    tick(); tick();
    n_checks++;
    if (ctl !== 8'b00110001) begin n_fail++; $display("FAIL reset ctl: got %b expected %b", ctl, 8'b00110001); end
    n_checks++;
    if ({bus.Address, bus.data_out, bus.rdata} !== 36'h0) begin
      n_fail++; $display("FAIL reset regs: got addr=%h dout=%h rdata=%h expected all 0", bus.Address, bus.data_out, bus.rdata);
    end
    RESET = 1'b0;
    tick();
    n_checks++;
    if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL reset req_ready: got %b expected 1", bus.req_ready); end
  endtask

  task automatic test_mem_read();
    logic [7:0] exp [5] = '{8'b10110000, 8'b00010000, 8'b00010000, 8'b00110100, 8'b00110001};
    bus.READY = 1'b1; bus.data_in = 8'h00;
    issue(1'b0, 1'b0, 20'h12345, 8'h00);
    for (int c = 0; c < 5; c++) begin
      n_checks++;
      if (ctl !== exp[c]) begin n_fail++; $display("FAIL mem_read ctl clk%0d: got %b expected %b", c + 1, ctl, exp[c]); end
      n_checks++;
      if (bus.Address !== 20'h12345) begin n_fail++; $display("FAIL mem_read addr clk%0d: got %h expected 12345", c + 1, bus.Address); end
      if (c == 2) bus.data_in = 8'hA5;
      if (c == 3) bus.data_in = 8'h00;
      if (c < 4) tick();
    end
    n_checks++;
    if (bus.rdata !== 8'hA5) begin n_fail++; $display("FAIL mem_read rdata: got %h expected a5", bus.rdata); end
  endtask

  task automatic test_io_write();
    logic [7:0] exp [5] = '{8'b11110000, 8'b01101000, 8'b01101000, 8'b01110100, 8'b01110001};
    bus.READY = 1'b1; bus.data_in = 8'h99;
    issue(1'b1, 1'b1, 20'h00080, 8'h3C);
    for (int c = 0; c < 5; c++) begin
      n_checks++;
      if (ctl !== exp[c]) begin n_fail++; $display("FAIL io_write ctl clk%0d: got %b expected %b", c + 1, ctl, exp[c]); end
      if (c == 1 || c == 2) begin
        n_checks++;
        if (bus.data_out !== 8'h3C) begin n_fail++; $display("FAIL io_write data_out clk%0d: got %h expected 3c", c + 1, bus.data_out); end
      end
      if (c < 4) tick();
    end
    n_checks++;
    if (bus.rdata !== 8'hA5 || bus.Address !== 20'h00080) begin
      n_fail++; $display("FAIL io_write hold: got rdata=%h addr=%h expected a5 00080", bus.rdata, bus.Address);
    end
  endtask

  task automatic test_wait_states();
    logic [7:0] exp [6] = '{8'b10110000, 8'b00010000, 8'b00010000, 8'b00010000, 8'b00010000, 8'b00110100};
    bus.READY = 1'b1; bus.data_in = 8'h11;
    issue(1'b0, 1'b0, 20'h00ABC, 8'h00);
    for (int c = 0; c < 6; c++) begin
      n_checks++;
      if (ctl !== exp[c]) begin n_fail++; $display("FAIL wait ctl clk%0d: got %b expected %b", c + 1, ctl, exp[c]); end
      if (c == 2) bus.READY = 1'b0;
      if (c == 4) begin bus.READY = 1'b1; bus.data_in = 8'h5A; end
      if (c < 5) tick();
    end
    n_checks++;
    if (bus.rdata !== 8'h5A) begin n_fail++; $display("FAIL wait rdata: got %h expected 5a", bus.rdata); end
    tick();
  endtask

  task automatic test_timeout();
    logic [7:0] exp;
    bus.READY = 1'b0; bus.data_in = 8'hFF;
    issue(1'b0, 1'b0, 20'h00777, 8'h00);
    for (int c = 0; c < 20; c++) begin
      exp = (c == 0) ? 8'b10110000 : (c < 18) ? 8'b00010000 : (c == 18) ? 8'b00110110 : 8'b00110001;
      n_checks++;
      if (ctl !== exp) begin n_fail++; $display("FAIL timeout ctl clk%0d: got %b expected %b", c + 1, ctl, exp); end
      if (c < 19) tick();
    end
    n_checks++;
    if (bus.rdata !== 8'h5A) begin n_fail++; $display("FAIL timeout rdata: got %h expected 5a", bus.rdata); end
    bus.READY = 1'b1;
  endtask

  task automatic test_reset_abort();
    bus.READY = 1'b0;
    issue(1'b1, 1'b0, 20'h00100, 8'h77);
    tick(); tick(); tick();
    n_checks++;
    if (ctl !== 8'b00101000 || bus.data_out !== 8'h77) begin
      n_fail++; $display("FAIL abort in_tw: got ctl=%b dout=%h expected 00101000 77", ctl, bus.data_out);
    end
    RESET = 1'b1;
    tick();
    n_checks++;
    if (ctl !== 8'b00110001) begin n_fail++; $display("FAIL abort after_reset ctl: got %b expected 00110001", ctl); end
    n_checks++;
    if ({bus.Address, bus.data_out, bus.rdata} !== 36'h0) begin
      n_fail++; $display("FAIL abort regs: got addr=%h dout=%h rdata=%h expected all 0", bus.Address, bus.data_out, bus.rdata);
    end
    RESET = 1'b0; bus.READY = 1'b1;
    tick();
    n_checks++;
    if (ctl !== 8'b00110001) begin n_fail++; $display("FAIL abort released ctl: got %b expected 00110001", ctl); end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  exp  [6] = '{8'b10110000, 8'b00010000, 8'b00010000, 8'b00110100, 8'b00110001, 8'b10110000};
    logic [19:0] eadr [6] = '{20'h0AAAA, 20'h0AAAA, 20'h0AAAA, 20'h0AAAA, 20'h0AAAA, 20'h05555};
    bus.READY = 1'b1; bus.data_in = 8'h3E;
    bus.req = 1'b1; bus.req_write = 1'b0; bus.req_io = 1'b0; bus.req_addr = 20'h0AAAA;
    tick();
    bus.req_addr = 20'h05555;
    for (int c = 0; c < 6; c++) begin
      n_checks++;
      if (ctl !== exp[c] || bus.Address !== eadr[c]) begin
        n_fail++; $display("FAIL b2b clk%0d: got ctl=%b addr=%h expected %b %h", c + 1, ctl, bus.Address, exp[c], eadr[c]);
      end
      if (c == 4) begin
        n_checks++;
        if (bus.rdata !== 8'h3E) begin n_fail++; $display("FAIL b2b rdata: got %h expected 3e", bus.rdata); end
      end
      if (c < 5) tick();
    end
    bus.req = 1'b0;
    tick(); tick(); tick();
    n_checks++;
    if (ctl !== 8'b00110100) begin n_fail++; $display("FAIL b2b second done: got %b expected 00110100", ctl); end
    tick();
  endtask

  initial begin
    RESET = 1'b1;
    bus.req = 1'b0; bus.req_write = 1'b0; bus.req_io = 1'b0;
    bus.req_addr = '0; bus.req_wdata = '0; bus.READY = 1'b1; bus.data_in = '0;
    test_reset();
    test_mem_read();
    test_io_write();
    test_wait_states();
    test_timeout();
    test_reset_abort();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
